// File: rtl/rv32v_types_pkg.sv
// rv32v_types_pkg: shared RV32V vector types plus store-sequencer state and sizing.
`default_nettype none

package rv32v_types_pkg;

  localparam int VLENB            = 16;
  localparam int VSTORE_MAX_WORDS = VLENB / 4 + 1;

  typedef logic [VLENB*8-1:0] vreg_t;

  typedef enum logic [2:0] {
    SEW8  = 3'd0,
    SEW16 = 3'd1,
    SEW32 = 3'd2,
    SEW64 = 3'd3
  } vsew_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FIN  = 2'd2
  } vstore_state_t;

endpackage

`default_nettype wire

// File: rtl/rv32v_store_lane_pack.sv
// rv32v_store_lane_pack: maps stream bytes onto the four lanes of output word k.
`default_nettype none

module rv32v_store_lane_pack #(
  parameter int VLENB = 16,
  parameter int TW    = $clog2(VLENB + 1),
  parameter int IW    = $clog2(VLENB)
) (
  input  logic [VLENB*8-1:0] i_vdata,
  input  logic [VLENB-1:0]   i_active,
  input  logic [1:0]         i_off,
  input  logic [TW-1:0]      i_total,
  input  logic [2:0]         i_k,
  output logic [31:0]        o_wdata,
  output logic [3:0]         o_byte_en
);

  int w_b;

  always_comb begin
    o_wdata   = '0;
    o_byte_en = '0;
    w_b       = 0;
    for (int j = 0; j < 4; j++) begin
      // Lane j of word k holds stream byte 4k + j - off; negative means before element 0.
      w_b = 4 * int'(i_k) + j - int'(i_off);
      if ((w_b >= 0) && (w_b < int'(i_total)) && i_active[IW'(w_b)]) begin
        o_byte_en[j]     = 1'b1;
        o_wdata[8*j +: 8] = 8'(i_vdata >> (8 * w_b));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv32v_store_sequencer.sv
// rv32v_store_sequencer: unit-stride LMUL1 vector store to 32-bit word writes.
// Optional build macro VSTORE_SKIP_EMPTY_EN suppresses words with no enabled lanes.
`default_nettype none

module rv32v_store_sequencer #(
  parameter int VLENB   = 16,
  parameter int VL_BITS = 5
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [VL_BITS-1:0]   vl,
  input  logic [2:0]           vsew,
  input  logic                 vm,
  input  logic [VLENB-1:0]     vmask,
  input  logic [VLENB*8-1:0]   vdata,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 mem_wen,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_byte_en,
  input  logic                 mem_busy
);

  import rv32v_types_pkg::*;

  localparam int TW   = $clog2(VLENB + 1);
  localparam int IW   = $clog2(VLENB);
  localparam int MAXW = VLENB / 4 + 1;
  localparam int LW   = 4 * MAXW;

  vstore_state_t      r_state, w_state_nxt;
  logic [29:0]        r_waddr;
  logic [1:0]         r_off;
  logic [TW-1:0]      r_total;
  logic [VLENB-1:0]   r_active;
  logic [VLENB*8-1:0] r_data;
  logic [2:0]         r_nwords, r_k, w_k_nxt;
  logic               r_err;

  logic               w_accept, w_illegal, w_wen;
  logic [31:0]        w_span;
  logic [TW-1:0]      w_total;
  logic [2:0]         w_nwords, w_cur, w_nxt;
  logic [VLENB-1:0]   w_active;
  logic [31:0]        w_wdata;
  logic [3:0]         w_byte_en;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_illegal = (vsew >= SEW64);
  assign w_span    = 32'(vl) << vsew[1:0];
  assign w_total   = (w_span > 32'(VLENB)) ? TW'(VLENB) : TW'(w_span);
  assign w_nwords  = 3'((32'(w_total) + 32'(base_addr[1:0]) + 32'd3) >> 2);

  always_comb begin
    w_active = '0;
    for (int b = 0; b < VLENB; b++) begin
      w_active[b] = (b < int'(w_total)) && (vm || vmask[IW'(b >> vsew[1:0])]);
    end
  end

`ifdef VSTORE_SKIP_EMPTY_EN
  logic [LW-1:0] w_lanes;

  // Lowest word index in [from, lim) with any enabled lane, or lim when none remain.
  function automatic logic [2:0] first_live_word(input logic [LW-1:0] lanes,
                                                 input logic [2:0] from,
                                                 input logic [2:0] lim);
    logic [2:0] sel;
    sel = lim;
    for (int i = MAXW - 1; i >= 0; i--) begin
      if ((3'(i) >= from) && (3'(i) < lim) && (|lanes[4*i +: 4])) sel = 3'(i);
    end
    return sel;
  endfunction

  assign w_lanes = {{(LW-VLENB){1'b0}}, r_active} << r_off;
  assign w_cur   = first_live_word(w_lanes, r_k, r_nwords);
  assign w_nxt   = first_live_word(w_lanes, w_cur + 3'd1, r_nwords);
`else
  assign w_cur   = r_k;
  assign w_nxt   = r_k + 3'd1;
`endif

  assign w_wen = (r_state == REQ) && (w_cur < r_nwords);

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_k_nxt     = '0;
          w_state_nxt = ((vl == '0) || w_illegal) ? FIN : REQ;
        end
      end
      REQ: begin
        if (!w_wen) begin
          w_state_nxt = FIN;
        end else if (!mem_busy) begin
          if (w_nxt >= r_nwords) w_state_nxt = FIN;
          else                   w_k_nxt     = w_nxt;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_waddr  <= '0;
      r_off    <= '0;
      r_total  <= '0;
      r_active <= '0;
      r_data   <= '0;
      r_nwords <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      if (w_accept) begin
        r_waddr  <= base_addr[31:2];
        r_off    <= base_addr[1:0];
        r_total  <= w_total;
        r_active <= w_active;
        r_data   <= vdata;
        r_nwords <= w_nwords;
        r_err    <= w_illegal;
      end
    end
  end

  rv32v_store_lane_pack #(
    .VLENB (VLENB),
    .TW    (TW),
    .IW    (IW)
  ) u_lane_pack (
    .i_vdata   (r_data),
    .i_active  (r_active),
    .i_off     (r_off),
    .i_total   (r_total),
    .i_k       (w_cur),
    .o_wdata   (w_wdata),
    .o_byte_en (w_byte_en)
  );

  // Bus fields are forced to zero whenever no request is presented.
  assign mem_wen     = w_wen;
  assign mem_addr    = w_wen ? {r_waddr + 30'(w_cur), 2'b00} : 32'd0;
  assign mem_wdata   = w_wen ? w_wdata : 32'd0;
  assign mem_byte_en = w_wen ? w_byte_en : 4'd0;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == FIN);
  assign error       = (r_state == FIN) && r_err;

endmodule

`default_nettype wire

// File: tb/tb_rv32v_store_sequencer.sv
// tb_rv32v_store_sequencer: directed stimulus with a queue scoreboard and bus monitor.
`default_nettype none

module tb_rv32v_store_sequencer;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         start;
  logic [31:0]  base_addr;
  logic [4:0]   vl;
  logic [2:0]   vsew;
  logic         vm;
  logic [15:0]  vmask;
  logic [127:0] vdata;
  logic         busy, done, error, mem_wen;
  logic [31:0]  mem_addr, mem_wdata;
  logic [3:0]   mem_byte_en;
  logic         mem_busy;

  rv32v_store_sequencer #(.VLENB(16), .VL_BITS(5)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .start       (start),
    .base_addr   (base_addr),
    .vl          (vl),
    .vsew        (vsew),
    .vm          (vm),
    .vmask       (vmask),
    .vdata       (vdata),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_byte_en (mem_byte_en),
    .mem_busy    (mem_busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  bit  done_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_cpl = 0;
  int n_cpl_txn = 0;
  bit wen_seen = 1'b0;
  int n_done = 0;
  int n_exp_done = 0;

  localparam logic [127:0] VD = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t w;
    w.a = a; w.d = d; w.be = be;
    exp_q.push_back(w);
  endtask

  task automatic issue(input logic [31:0] ba, input logic [4:0] l, input logic [2:0] sw,
                       input logic m, input logic [15:0] mk, input bit err, input bit exp_done);
    base_addr = ba; vl = l; vsew = sw; vm = m; vmask = mk; vdata = VD;
    start     = 1'b1;
    start_cyc = cyc;
    wen_seen  = 1'b0;
    n_cpl_txn = 0;
    if (exp_done) begin
      done_q.push_back(err);
      n_exp_done++;
    end
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && n_done < n_exp_done; k++) begin
      @(negedge CLK); #1;
    end
    if (n_done < n_exp_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got %0d done pulses expected %0d", n_done, n_exp_done);
      n_done = n_exp_done;
      done_q.delete();
      exp_q.delete();
    end
    @(posedge CLK); #1;
  endtask

  // Monitor: compares every presented word against the scoreboard head.
  always @(negedge CLK) begin
    if (nRST) begin
      if (mem_wen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
        end else begin
          if (!wen_seen) begin
            chk("first_wen_latency", 32'(cyc - start_cyc), 32'd1);
            wen_seen = 1'b1;
          end
          chk("mem_addr", mem_addr, exp_q[0].a);
          chk("mem_wdata", mem_wdata, exp_q[0].d);
          chk("mem_byte_en", 32'(mem_byte_en), 32'(exp_q[0].be));
          if (!mem_busy) begin
            void'(exp_q.pop_front());
            last_cpl = cyc;
            n_cpl_txn++;
          end
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          chk("error_flag", 32'(error), 32'(done_q.pop_front()));
          chk("writes_left_at_done", 32'(exp_q.size()), 32'd0);
          if (n_cpl_txn > 0) chk("done_latency", 32'(cyc - last_cpl), 32'd1);
          else               chk("done_latency", 32'(cyc - start_cyc), 32'd1);
          chk("busy_at_done", 32'(busy), 32'd1);
        end
        n_done++;
      end else if (error) begin
        chk("error_without_done", 32'(error), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; start = 1'b0; base_addr = '0; vl = '0; vsew = '0;
    vm = 1'b1; vmask = '0; vdata = '0; mem_busy = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_mem_wen", 32'(mem_wen), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_mem_byte_en", 32'(mem_byte_en), 32'd0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Aligned SEW32, four full words
    push_wr(32'h1000, 32'h03020100, 4'hF);
    push_wr(32'h1004, 32'h07060504, 4'hF);
    push_wr(32'h1008, 32'h0B0A0908, 4'hF);
    push_wr(32'h100C, 32'h0F0E0D0C, 4'hF);
    issue(32'h1000, 5'd4, 3'd2, 1'b1, 16'h0000, 1'b0, 1'b1);
    wait_done();

    // Unaligned SEW8, vl=5 at offset 3
    push_wr(32'h2000, 32'h00000000, 4'b1000);
    push_wr(32'h2004, 32'h04030201, 4'hF);
    issue(32'h2003, 5'd5, 3'd0, 1'b1, 16'h0000, 1'b0, 1'b1);
    wait_done();

    // Masked SEW16: elements 0 and 2 only
    push_wr(32'h3000, 32'h00000100, 4'b0011);
    push_wr(32'h3004, 32'h00000504, 4'b0011);
    issue(32'h3000, 5'd4, 3'd1, 1'b0, 16'b0101, 1'b0, 1'b1);
    wait_done();

    // Masked SEW16 whose second word has no enabled lanes
    push_wr(32'h3000, 32'h03020100, 4'hF);
`ifndef VSTORE_SKIP_EMPTY_EN
    push_wr(32'h3004, 32'h00000000, 4'b0000);
`endif
    issue(32'h3000, 5'd4, 3'd1, 1'b0, 16'b0011, 1'b0, 1'b1);
    wait_done();

    // vl=0: immediate done, no writes
    issue(32'h4000, 5'd0, 3'd0, 1'b1, 16'h0000, 1'b0, 1'b1);
    wait_done();

    // SEW64: done with error, no writes
    issue(32'h4100, 5'd4, 3'd3, 1'b1, 16'h0000, 1'b1, 1'b1);
    wait_done();

    // SEW32 vl=8 clamped to 16 bytes, 3-cycle stall on word 0, stray start while busy
    push_wr(32'h5000, 32'h03020100, 4'hF);
    push_wr(32'h5004, 32'h07060504, 4'hF);
    push_wr(32'h5008, 32'h0B0A0908, 4'hF);
    push_wr(32'h500C, 32'h0F0E0D0C, 4'hF);
    mem_busy = 1'b1;
    issue(32'h5000, 5'd8, 3'd2, 1'b1, 16'h0000, 1'b0, 1'b1);
    start = 1'b1; base_addr = 32'h9000; vl = 5'd1; vsew = 3'd0;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    mem_busy = 1'b0;
    wait_done();

    // Reset asserted while a word is pending
    mem_busy = 1'b1;
    push_wr(32'h6000, 32'h03020100, 4'hF);
    issue(32'h6000, 5'd4, 3'd2, 1'b1, 16'h0000, 1'b0, 1'b0);
    @(negedge CLK); #2;
    nRST = 1'b0;
    #1;
    chk("abort_mem_wen", 32'(mem_wen), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    exp_q.delete();
    @(posedge CLK); #1;
    nRST = 1'b1;
    mem_busy = 1'b0;
    @(posedge CLK); #1;
    chk("post_abort_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge CLK);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
